// File: rtl/bin_to_bcd_pkg.sv
// bin_to_bcd_pkg: shared widths and limits for the binary-to-BCD converter
package bin_to_bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam int BIN_W = 8;
  localparam int BCD_MAX = 99;
endpackage

// File: rtl/bin_to_bcd_comb.sv
// bin_to_bcd_comb: combinational double-dabble core producing tens, units and overflow
module bin_to_bcd_comb
  import bin_to_bcd_pkg::*;
(
  input  logic [BIN_W-1:0]       i_binary,
  output logic [BCD_DIGIT_W-1:0] o_tens,
  output logic [BCD_DIGIT_W-1:0] o_units,
  output logic                   o_overflow
);
  logic [3*BCD_DIGIT_W-1:0] bcd;
  logic [BCD_DIGIT_W-1:0] h, t;
  logic sat;
  always_comb begin
    bcd = '0;
    for (int i = 0; i < BIN_W; i++) begin
      for (int d = 0; d < 3; d++)
        if (bcd[BCD_DIGIT_W*d +: BCD_DIGIT_W] >= 4'd5)
          bcd[BCD_DIGIT_W*d +: BCD_DIGIT_W] = bcd[BCD_DIGIT_W*d +: BCD_DIGIT_W] + 4'd3;
      bcd = {bcd[3*BCD_DIGIT_W-2:0], i_binary[BIN_W-1-i]};
    end
  end
  // hundreds fold into the tens digit up to 159; beyond that it pins at 15
  assign h = bcd[2*BCD_DIGIT_W +: BCD_DIGIT_W];
  assign t = bcd[BCD_DIGIT_W +: BCD_DIGIT_W];
  assign sat = (h >= 4'd2) || (h == 4'd1 && t >= 4'd6);
  assign o_tens = sat ? 4'hf : (h == 4'd1 ? t + 4'd10 : t);
  assign o_units = bcd[BCD_DIGIT_W-1:0];
  assign o_overflow = int'(i_binary) > BCD_MAX;
endmodule

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: registered binary-to-two-digit converter with capture enable
module bin_to_bcd
  import bin_to_bcd_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_en,
  input  logic [BIN_W-1:0]       i_binary,
  output logic [BCD_DIGIT_W-1:0] o_bcd_msb,
  output logic [BCD_DIGIT_W-1:0] o_bcd_lsb,
  output logic                   o_overflow
);
  logic [BCD_DIGIT_W-1:0] tens, units;
  logic ovf;
  bin_to_bcd_comb u_comb (
    .i_binary  (i_binary),
    .o_tens    (tens),
    .o_units   (units),
    .o_overflow(ovf)
  );
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_bcd_msb <= '0;
      o_bcd_lsb <= '0;
      o_overflow <= 1'b0;
    end else if (i_en) begin
      o_bcd_msb <= tens;
      o_bcd_lsb <= units;
      o_overflow <= ovf;
    end
  end
endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd: directed table and sequence checks for bin_to_bcd
module tb_bin_to_bcd;
  logic clk = 0, rst = 0, en = 0, ovf;
  logic [7:0] x = 0;
  logic [3:0] msb, lsb;
  int total = 0, bad = 0;

  typedef struct {
    logic [7:0] x;
    logic [3:0] msb;
    logic [3:0] lsb;
    logic       ovf;
  } vec_t;
  vec_t tbl [13];

  always #5 clk = ~clk;

  bin_to_bcd dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_en      (en),
    .i_binary  (x),
    .o_bcd_msb (msb),
    .o_bcd_lsb (lsb),
    .o_overflow(ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] em, input logic [3:0] el, input logic eo);
    total++;
    if (msb !== em || lsb !== el || ovf !== eo) begin
      bad++;
      $display("FAIL %s: got msb=%0d lsb=%0d ovf=%b, want msb=%0d lsb=%0d ovf=%b",
               name, msb, lsb, ovf, em, el, eo);
    end
  endtask

  initial begin
    tbl[0]  = '{8'd0,   4'd0,  4'd0, 1'b0};
    tbl[1]  = '{8'd9,   4'd0,  4'd9, 1'b0};
    tbl[2]  = '{8'd10,  4'd1,  4'd0, 1'b0};
    tbl[3]  = '{8'd59,  4'd5,  4'd9, 1'b0};
    tbl[4]  = '{8'd99,  4'd9,  4'd9, 1'b0};
    tbl[5]  = '{8'd100, 4'd10, 4'd0, 1'b1};
    tbl[6]  = '{8'd127, 4'd12, 4'd7, 1'b1};
    tbl[7]  = '{8'd155, 4'd15, 4'd5, 1'b1};
    tbl[8]  = '{8'd159, 4'd15, 4'd9, 1'b1};
    tbl[9]  = '{8'd160, 4'd15, 4'd0, 1'b1};
    tbl[10] = '{8'd199, 4'd15, 4'd9, 1'b1};
    tbl[11] = '{8'd255, 4'd15, 4'd5, 1'b1};
    tbl[12] = '{8'd23,  4'd2,  4'd3, 1'b0};

    rst = 1; en = 1; x = 8'd57;
    tick(); check("reset1", 4'd0, 4'd0, 1'b0);
    tick(); check("reset2", 4'd0, 4'd0, 1'b0);
    rst = 0;
    tick(); check("post_reset", 4'd5, 4'd7, 1'b0);

    for (int i = 0; i < 128; i++) begin
      x = 8'(i);
      rst = (i == 73);
      tick();
      if (i == 73) check("mid_reset", 4'd0, 4'd0, 1'b0);
      else check("sweep", 4'(i / 10), 4'(i % 10), i > 99);
    end
    rst = 0;

    foreach (tbl[i]) begin
      x = tbl[i].x;
      tick();
      check("table", tbl[i].msb, tbl[i].lsb, tbl[i].ovf);
    end

    x = 8'd42;
    tick(); check("hold_cap", 4'd4, 4'd2, 1'b0);
    en = 0; x = 8'd17;
    for (int i = 0; i < 5; i++) begin
      tick(); check("hold", 4'd4, 4'd2, 1'b0);
    end
    en = 1;
    tick(); check("hold_release", 4'd1, 4'd7, 1'b0);

    x = 8'd200;
    tick(); check("ovf_cap", 4'd15, 4'd0, 1'b1);
    en = 0; x = 8'd5;
    tick(); check("ovf_hold", 4'd15, 4'd0, 1'b1);
    rst = 1;
    tick(); check("reset_over_hold", 4'd0, 4'd0, 1'b0);
    rst = 0; en = 1;
    tick(); check("resume", 4'd0, 4'd5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
